riscv_dmem_responder: RTL and testbench

RISCV_DMEM_RESPONDER -- requirements
Module: riscv_dmem_responder

---
 rtl/riscv_mem_pkg.sv | 14 +
 rtl/riscv_dmem_responder_tx_fifo.sv | 42 ++++
 rtl/riscv_dmem_responder.sv | 83 ++++++++
 tb/tb_riscv_dmem_responder.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg: shared MMIO map, responder FSM states and STATUS register layout
package riscv_mem_pkg;
  localparam logic [31:0] MMIO_BASE   = 32'h8000_0000;
  localparam logic [31:0] TXDATA_OFF  = 32'h0000_0000;
  localparam logic [31:0] STATUS_OFF  = 32'h0000_0004;
  localparam logic [31:0] TXDATA_ADDR = MMIO_BASE + TXDATA_OFF;
  localparam logic [31:0] STATUS_ADDR = MMIO_BASE + STATUS_OFF;
  typedef enum logic {ST_IDLE, ST_RESP} state_t;
  typedef struct packed {
    logic [26:0] zero;
    logic [3:0]  count;
    logic        full;
  } status_t;
endpackage

// File: rtl/riscv_dmem_responder_tx_fifo.sv
// tx_fifo: power-of-two byte queue feeding the UART transmitter
// Ports: clk/rst (async active-low); push/din enqueue; pop dequeue (ignored when empty);
//   dout head entry; count 0..DEPTH; full/empty status.
module tx_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_cnt;
  logic w_push, w_pop;
  assign empty = r_cnt == '0;
  assign full = r_cnt == (AW+1)'(DEPTH);
  assign count = r_cnt;
  assign dout = r_mem[r_rp];
  assign w_pop = pop && !empty;
  // a push into a full queue is legal when a pop frees the head slot in the same cycle
  assign w_push = push && (!full || w_pop);
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= din;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end
endmodule

// File: rtl/riscv_dmem_responder.sv
// riscv_dmem_responder: single-outstanding data-memory responder with optional UART TX MMIO
// Ports: clk/rst (async active-low); req_valid/write/addr/wdata/wstrb core request, req_ready accept;
//   rsp_valid/rsp_rdata one-cycle response; tx_valid/tx_data/tx_ready UART byte stream; err sticky.
// Define DMEM_MMIO_TX_EN to compile the TXDATA/STATUS registers and the TX FIFO.
module riscv_dmem_responder
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int TXQ_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  logic [31:0] r_ram [DEPTH_WORDS];
  state_t r_state;
  logic r_rsp_valid, r_err;
  logic [31:0] r_rsp_rdata;
  logic w_accept, w_in_ram, w_is_tx, w_is_st, w_stall, w_unused;
  logic [AW-1:0] w_idx;
  logic [31:0] w_mmio_rdata, w_rdata;
  assign w_idx = req_addr[AW+1:2];
  assign w_in_ram = req_addr[31:AW+2] == '0;
`ifdef DMEM_MMIO_TX_EN
  logic w_full, w_empty;
  logic [$clog2(TXQ_DEPTH):0] w_count;
  status_t w_status;
  assign w_is_tx = req_addr[31:2] == TXDATA_ADDR[31:2];
  assign w_is_st = req_addr[31:2] == STATUS_ADDR[31:2];
  assign w_status = '{zero: '0, count: 4'(w_count), full: w_full};
  assign w_mmio_rdata = w_is_st ? w_status : '0;
  assign w_stall = req_write && w_is_tx && w_full;
  assign tx_valid = !w_empty;
  assign w_unused = ^req_addr[1:0];
  tx_fifo #(.DEPTH(TXQ_DEPTH), .W(8)) u_txq (
    .clk(clk), .rst(rst), .push(w_accept && req_write && w_is_tx), .din(req_wdata[7:0]),
    .pop(tx_ready), .dout(tx_data), .count(w_count), .full(w_full), .empty(w_empty)
  );
`else
  assign w_is_tx = 1'b0;
  assign w_is_st = 1'b0;
  assign w_mmio_rdata = '0;
  assign w_stall = 1'b0;
  assign tx_valid = 1'b0;
  assign tx_data = '0;
  assign w_unused = ^{req_addr[1:0], tx_ready};
`endif
  // rst gates req_ready directly so it is low throughout reset and high as soon as reset releases
  assign req_ready = rst && r_state == ST_IDLE && !w_stall;
  assign w_accept = req_valid && req_ready;
  assign w_rdata = req_write ? '0 : w_in_ram ? r_ram[w_idx] : w_mmio_rdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign err = r_err;
  always_ff @(posedge clk)
    if (w_accept && req_write && w_in_ram)
      for (int b = 0; b < 4; b++)
        if (req_wstrb[b]) r_ram[w_idx][b*8 +: 8] <= req_wdata[b*8 +: 8];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state <= ST_IDLE;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_err <= 1'b0;
    end else begin
      r_state <= w_accept ? ST_RESP : ST_IDLE;
      r_rsp_valid <= w_accept;
      if (w_accept) r_rsp_rdata <= w_rdata;
      if (w_accept && !(w_in_ram || w_is_tx || w_is_st)) r_err <= 1'b1;
    end
endmodule

// File: tb/tb_riscv_dmem_responder.sv
// tb_riscv_dmem_responder: directed self-checking bench for riscv_dmem_responder
module tb_riscv_dmem_responder;
  logic clk = 0, rst = 0;
  logic req_valid = 0, req_write = 0, req_ready, rsp_valid, tx_valid, tx_ready = 0, err;
  logic [31:0] req_addr = 0, req_wdata = 0, rsp_rdata;
  logic [3:0] req_wstrb = 0;
  logic [7:0] tx_data;
  int n_cmp = 0, n_fail = 0;
  logic [7:0] cap [$];
  logic acc, v1, v2;
  logic [31:0] rd;

  riscv_dmem_responder #(.DEPTH_WORDS(4096), .TXQ_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (tx_valid && tx_ready) cap.push_back(tx_data);

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       output logic o_acc, output logic o_v1, output logic [31:0] o_rd, output logic o_v2);
    @(negedge clk);
    req_valid = 1; req_write = w; req_addr = a; req_wdata = d; req_wstrb = s;
    o_acc = 0; o_v1 = 0; o_rd = '0; o_v2 = 0;
    for (int i = 0; i < 20 && !o_acc; i++) begin
      #1;
      if (req_ready) o_acc = 1;
      else @(negedge clk);
    end
    if (o_acc) begin
      @(posedge clk);
      @(negedge clk);
      req_valid = 0;
      o_v1 = rsp_valid; o_rd = rsp_rdata;
      @(negedge clk);
      o_v2 = rsp_valid;
    end else req_valid = 0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", req_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
    n_cmp++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", rsp_rdata); end
    n_cmp++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_tx_valid: got %b want 0", tx_valid); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", err); end
    rst = 1;
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rel_ready: got %b want 1", req_ready); end
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rel_ready2: got %b want 1", req_ready); end
  endtask

  task automatic test_store_load;
    issue(1, 32'h10, 32'hDEADBEEF, 4'hF, acc, v1, rd, v2);
    n_cmp++; if (acc !== 1'b1) begin n_fail++; $display("FAIL st_acc: got %b want 1", acc); end
    n_cmp++; if (v1 !== 1'b1) begin n_fail++; $display("FAIL st_rsp: got %b want 1", v1); end
    n_cmp++; if (v2 !== 1'b0) begin n_fail++; $display("FAIL st_rsp_pulse: got %b want 0", v2); end
    issue(0, 32'h10, 32'h0, 4'h0, acc, v1, rd, v2);
    n_cmp++; if (v1 !== 1'b1) begin n_fail++; $display("FAIL ld_rsp: got %b want 1", v1); end
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ld_data: got %h want deadbeef", rd); end
    n_cmp++; if (v2 !== 1'b0) begin n_fail++; $display("FAIL ld_rsp_pulse: got %b want 0", v2); end
    issue(1, 32'h0, 32'h11223344, 4'hF, acc, v1, rd, v2);
    issue(0, 32'h0, 32'h0, 4'h0, acc, v1, rd, v2);
    n_cmp++; if (rd !== 32'h11223344) begin n_fail++; $display("FAIL ld_w0: got %h want 11223344", rd); end
  endtask

  task automatic test_byte_strobe;
    issue(1, 32'h10, 32'h000000AA, 4'b0001, acc, v1, rd, v2);
    issue(0, 32'h10, 32'h0, 4'h0, acc, v1, rd, v2);
    n_cmp++; if (rd !== 32'hDEADBEAA) begin n_fail++; $display("FAIL strb_b0: got %h want deadbeaa", rd); end
    issue(1, 32'h10, 32'h12340000, 4'b1100, acc, v1, rd, v2);
    issue(0, 32'h13, 32'h0, 4'h0, acc, v1, rd, v2);
    n_cmp++; if (rd !== 32'h1234BEAA) begin n_fail++; $display("FAIL strb_hi: got %h want 1234beaa", rd); end
    issue(1, 32'h3FFC, 32'hCAFEF00D, 4'hF, acc, v1, rd, v2);
    issue(0, 32'h3FFC, 32'h0, 4'h0, acc, v1, rd, v2);
    n_cmp++; if (rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL last_word: got %h want cafef00d", rd); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL in_range_err: got %b want 0", err); end
  endtask

  task automatic test_out_of_range;
    issue(0, 32'h0010_0000, 32'h0, 4'h0, acc, v1, rd, v2);
    n_cmp++; if (v1 !== 1'b1) begin n_fail++; $display("FAIL oor_rsp: got %b want 1", v1); end
    n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL oor_data: got %h want 0", rd); end
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL oor_err: got %b want 1", err); end
    issue(1, 32'h4000, 32'hFFFFFFFF, 4'hF, acc, v1, rd, v2);
    n_cmp++; if (v1 !== 1'b1) begin n_fail++; $display("FAIL oor_st_rsp: got %b want 1", v1); end
    issue(0, 32'h0, 32'h0, 4'h0, acc, v1, rd, v2);
    n_cmp++; if (rd !== 32'h11223344) begin n_fail++; $display("FAIL oor_no_alias: got %h want 11223344", rd); end
    repeat (3) @(negedge clk);
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", err); end
  endtask

  task automatic test_reset_midflight;
    issue(1, 32'h8000_0000, 32'h55, 4'hF, acc, v1, rd, v2);
    @(negedge clk);
    req_valid = 1; req_write = 0; req_addr = 32'h10;
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL mf_ready: got %b want 1", req_ready); end
    @(posedge clk);
    #1 rst = 0; req_valid = 0;
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mf_rsp: got %b want 0", rsp_valid); end
    n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL mf_ready_rst: got %b want 0", req_ready); end
    n_cmp++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL mf_fifo: got %b want 0", tx_valid); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL mf_err: got %b want 0", err); end
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mf_rsp2: got %b want 0", rsp_valid); end
    rst = 1;
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL mf_rel_ready: got %b want 1", req_ready); end
    issue(0, 32'h10, 32'h0, 4'h0, acc, v1, rd, v2);
    n_cmp++; if (rd !== 32'h1234BEAA) begin n_fail++; $display("FAIL ram_kept: got %h want 1234beaa", rd); end
  endtask

`ifdef DMEM_MMIO_TX_EN
  task automatic test_tx_fifo;
    logic stall;
    tx_ready = 0;
    cap.delete();
    for (int i = 0; i < 8; i++) begin
      issue(1, 32'h8000_0000, 32'h41 + i, 4'hF, acc, v1, rd, v2);
      n_cmp++; if (acc !== 1'b1) begin n_fail++; $display("FAIL tx_push%0d: got %b want 1", i, acc); end
    end
    issue(0, 32'h8000_0004, 32'h0, 4'h0, acc, v1, rd, v2);
    n_cmp++; if (rd !== 32'h11) begin n_fail++; $display("FAIL status_full: got %h want 11", rd); end
    n_cmp++; if (tx_data !== 8'h41) begin n_fail++; $display("FAIL tx_head: got %h want 41", tx_data); end
    @(negedge clk);
    req_valid = 1; req_write = 1; req_addr = 32'h8000_0000; req_wdata = 32'h49; req_wstrb = 4'hF;
    stall = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      if (req_ready) stall = 0;
      @(negedge clk);
    end
    n_cmp++; if (stall !== 1'b1) begin n_fail++; $display("FAIL tx_stall: got %b want 1", stall); end
    @(posedge clk);
    #1 tx_ready = 1;
    acc = 0;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      #1;
      if (req_ready) acc = 1;
    end
    if (acc) begin
      @(posedge clk);
      @(negedge clk);
    end
    req_valid = 0;
    n_cmp++; if (acc !== 1'b1) begin n_fail++; $display("FAIL tx_ninth: got %b want 1", acc); end
    repeat (15) @(negedge clk);
    n_cmp++; if (cap.size() !== 9) begin n_fail++; $display("FAIL tx_count: got %0d want 9", cap.size()); end
    for (int i = 0; i < 9 && i < cap.size(); i++) begin
      n_cmp++; if (cap[i] !== 8'(8'h41 + i)) begin n_fail++; $display("FAIL tx_byte%0d: got %h want %h", i, cap[i], 8'(8'h41 + i)); end
    end
    n_cmp++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL tx_drained: got %b want 0", tx_valid); end
    issue(0, 32'h8000_0004, 32'h0, 4'h0, acc, v1, rd, v2);
    n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL status_empty: got %h want 0", rd); end
    issue(0, 32'h8000_0000, 32'h0, 4'h0, acc, v1, rd, v2);
    n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL txdata_ld: got %h want 0", rd); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL tx_err: got %b want 0", err); end
    tx_ready = 0;
  endtask
`else
  task automatic test_no_mmio;
    logic seen;
    tx_ready = 1;
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL nm_err0: got %b want 0", err); end
    issue(1, 32'h8000_0000, 32'h41, 4'hF, acc, v1, rd, v2);
    n_cmp++; if (v1 !== 1'b1) begin n_fail++; $display("FAIL nm_rsp: got %b want 1", v1); end
    seen = tx_valid;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (tx_valid) seen = 1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL nm_tx_valid: got %b want 0", seen); end
    n_cmp++; if (tx_data !== 8'h0) begin n_fail++; $display("FAIL nm_tx_data: got %h want 0", tx_data); end
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL nm_err: got %b want 1", err); end
    tx_ready = 0;
  endtask
`endif

  initial begin
    test_reset;
    test_store_load;
    test_byte_strobe;
    test_out_of_range;
    test_reset_midflight;
`ifdef DMEM_MMIO_TX_EN
    test_tx_fifo;
`else
    test_no_mmio;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
